// File: rtl/redmule_pkg.sv
// Shared constants for the RedMulE configuration master.
//   REDMULE_REGS     : default number of job registers written per job
//   REDMULE_TRIGGER  : byte offset of the TRIGGER register
//   REDMULE_ACQUIRE  : byte offset of the ACQUIRE register
//   REDMULE_ACQ_BUSY : ACQUIRE read value meaning "no free context, retry"
//   cfg_state_t      : FSM state encoding of redmule_cfg_master
package redmule_pkg;

   localparam int unsigned REDMULE_REGS     = 4;

   localparam logic [31:0] REDMULE_TRIGGER  = 32'h0000_0000;
   localparam logic [31:0] REDMULE_ACQUIRE  = 32'h0000_0004;
   localparam logic [31:0] REDMULE_ACQ_BUSY = 32'hFFFF_FFFF;

   typedef logic [2:0] cfg_state_t;

   localparam cfg_state_t CFG_IDLE     = 3'd0;
   localparam cfg_state_t CFG_ACQ_REQ  = 3'd1;
   localparam cfg_state_t CFG_ACQ_RSP  = 3'd2;
   localparam cfg_state_t CFG_RETRY    = 3'd3;
   localparam cfg_state_t CFG_WRITE    = 3'd4;
   localparam cfg_state_t CFG_TRIGGER  = 3'd5;
   localparam cfg_state_t CFG_WAIT_EVT = 3'd6;
   localparam cfg_state_t CFG_DONE     = 3'd7;

endpackage

// File: rtl/redmule_cfg_master.sv
// Configuration master that programs one RedMulE job over the hwpe periph bus.
// A job descriptor is latched, a context is acquired (retrying while the
// accelerator reports busy), the job registers are written back to back, the
// job is triggered and the master waits for the job-end event.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous abort back to IDLE
//   job_valid_i/ready_o  descriptor handshake, job_regs_i the descriptor words
//   evt_i                hwpe events of this core, bit 0 = job end
//   periph_*             flat periph master (request / grant / read response)
//   busy_o, done_o       job in flight, one-cycle pulse at job end
//   job_id_o             context ID returned by the last successful ACQUIRE
module redmule_cfg_master
   import redmule_pkg::*;
#(
   parameter int unsigned ID_WIDTH     = 8,
   parameter int unsigned N_JOB_REGS   = REDMULE_REGS,
   parameter logic [31:0] JOB_BASE     = 32'h40,
   parameter int unsigned RETRY_CYCLES = 4,
   parameter int unsigned MASTER_ID    = 0
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     job_valid_i,
   output logic                     job_ready_o,
   input  logic [N_JOB_REGS*32-1:0] job_regs_i,
   input  logic [1:0]               evt_i,
   output logic                     periph_req_o,
   input  logic                     periph_gnt_i,
   output logic [31:0]              periph_add_o,
   output logic                     periph_wen_o,
   output logic [3:0]               periph_be_o,
   output logic [31:0]              periph_data_o,
   output logic [ID_WIDTH-1:0]      periph_id_o,
   input  logic                     periph_r_valid_i,
   input  logic [31:0]              periph_r_data_i,
   input  logic [ID_WIDTH-1:0]      periph_r_id_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [7:0]               job_id_o
);

   localparam int unsigned KW = $clog2(N_JOB_REGS + 1);
   // +2 keeps the counter at least one bit wide when RETRY_CYCLES is 0
   localparam int unsigned RW = $clog2(RETRY_CYCLES + 2);
   localparam logic [ID_WIDTH-1:0] MID    = ID_WIDTH'(MASTER_ID);
   localparam logic [KW-1:0]       K_LAST = KW'(N_JOB_REGS - 1);

   cfg_state_t                     state_q, state_d;
   logic [KW-1:0]                  k_q, k_d;
   logic [RW-1:0]                  retry_q, retry_d;
   logic                           evt_q, evt_d;
   logic [7:0]                     job_id_q, job_id_d;
   logic [N_JOB_REGS-1:0][31:0]    regs_q, regs_d;

   logic        rsp_hit;
   logic        retry_done;
   logic [31:0] wdata;
   logic        unused_evt_hi;

   assign unused_evt_hi = evt_i[1];

   assign rsp_hit    = periph_r_valid_i && (periph_r_id_i == MID);
   // RETRY always lasts at least one cycle, so RETRY_CYCLES=0 behaves like 1
   assign retry_done = (32'(retry_q) + 32'd1) >= RETRY_CYCLES;

   always_comb begin
      wdata = '0;
      for (int unsigned i = 0; i < N_JOB_REGS; i++) begin
         if (k_q == KW'(i)) wdata = regs_q[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      retry_d  = retry_q;
      job_id_d = job_id_q;
      regs_d   = regs_q;
      // job-end events seen before WAIT_EVT are remembered here
      evt_d    = evt_q | evt_i[0];

      case (state_q)
         CFG_IDLE: begin
            if (job_valid_i) begin
               regs_d  = job_regs_i;
               state_d = CFG_ACQ_REQ;
            end
         end
         CFG_ACQ_REQ: begin
            if (periph_gnt_i) state_d = CFG_ACQ_RSP;
         end
         CFG_ACQ_RSP: begin
            if (rsp_hit) begin
               if (periph_r_data_i == REDMULE_ACQ_BUSY) begin
                  retry_d = '0;
                  state_d = CFG_RETRY;
               end else begin
                  job_id_d = periph_r_data_i[7:0];
                  k_d      = '0;
                  state_d  = CFG_WRITE;
               end
            end
         end
         CFG_RETRY: begin
            if (retry_done) begin
               retry_d = '0;
               state_d = CFG_ACQ_REQ;
            end else begin
               retry_d = retry_q + 1'b1;
            end
         end
         CFG_WRITE: begin
            if (periph_gnt_i) begin
               k_d = k_q + 1'b1;
               if (k_q == K_LAST) state_d = CFG_TRIGGER;
            end
         end
         CFG_TRIGGER: begin
            if (periph_gnt_i) state_d = CFG_WAIT_EVT;
         end
         CFG_WAIT_EVT: begin
            evt_d = 1'b0;
            if (evt_i[0] || evt_q) state_d = CFG_DONE;
         end
         CFG_DONE: begin
            state_d = CFG_IDLE;
         end
         default: begin
            state_d = CFG_IDLE;
         end
      endcase

      if (job_ready_o && job_valid_i) evt_d = 1'b0;

      // abort wins over everything, including a response arriving this cycle
      if (clear_i) begin
         state_d  = CFG_IDLE;
         k_d      = '0;
         retry_d  = '0;
         evt_d    = 1'b0;
         job_id_d = job_id_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= CFG_IDLE;
         k_q      <= '0;
         retry_q  <= '0;
         evt_q    <= 1'b0;
         job_id_q <= '0;
         regs_q   <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         retry_q  <= retry_d;
         evt_q    <= evt_d;
         job_id_q <= job_id_d;
         regs_q   <= regs_d;
      end
   end

   // Request fields depend only on state, k and latched words, so they stay
   // stable while a request waits for its grant.
   always_comb begin
      periph_req_o  = 1'b0;
      periph_wen_o  = 1'b1;
      periph_add_o  = '0;
      periph_be_o   = 4'h0;
      periph_data_o = '0;
      periph_id_o   = MID;
      case (state_q)
         CFG_ACQ_REQ: begin
            periph_req_o = 1'b1;
            periph_wen_o = 1'b1;
            periph_add_o = REDMULE_ACQUIRE;
            periph_be_o  = 4'hF;
         end
         CFG_WRITE: begin
            periph_req_o  = 1'b1;
            periph_wen_o  = 1'b0;
            periph_add_o  = JOB_BASE + (32'(k_q) << 2);
            periph_be_o   = 4'hF;
            periph_data_o = wdata;
         end
         CFG_TRIGGER: begin
            periph_req_o  = 1'b1;
            periph_wen_o  = 1'b0;
            periph_add_o  = REDMULE_TRIGGER;
            periph_be_o   = 4'hF;
            periph_data_o = '0;
         end
         default: ;
      endcase
   end

   assign job_ready_o = (state_q == CFG_IDLE);
   assign busy_o      = (state_q != CFG_IDLE);
   assign done_o      = (state_q == CFG_DONE);
   assign job_id_o    = job_id_q;

endmodule

// File: doc/redmule_cfg_master.md
REDMULE_CFG_MASTER -- requirements
Module: redmule_cfg_master

Interface
REQ-001 Parameters SHALL be:
- ID_WIDTH, default 8, periph transaction ID width.
- N_JOB_REGS, default REDMULE_REGS, job registers written per job.
- JOB_BASE, default 32'h40, address of job register 0.
- RETRY_CYCLES, default 4, idle wait before re-issuing a failed ACQUIRE.
- MASTER_ID, default 0, ID driven on every request.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous abort to IDLE.
- job_valid_i  in  1  job descriptor valid.
- job_ready_o  out  1  descriptor accepted this cycle.
- job_regs_i  in  N_JOB_REGS x 32  descriptor words.
- evt_i  in  2  hwpe event lines of this core; bit 0 = job end.
- periph_req_o  out  1  request.
- periph_gnt_i  in  1  grant.
- periph_add_o  out  32  byte address.
- periph_wen_o  out  1  1 = read, 0 = write.
- periph_be_o  out  4  byte enables.
- periph_data_o  out  32  write data.
- periph_id_o  out  ID_WIDTH  request ID.
- periph_r_valid_i  in  1  read response valid.
- periph_r_data_i  in  32  read data.
- periph_r_id_i  in  ID_WIDTH  response ID.
- busy_o  out  1  job in flight.
- done_o  out  1  one-cycle pulse at job end.
- job_id_o  out  8  context ID returned by ACQUIRE, held until next acquire.

Function
REQ-003 Register offsets SHALL be TRIGGER 0x00, ACQUIRE 0x04, and job register k at JOB_BASE+4k.
REQ-004 The FSM SHALL have the states IDLE, ACQ_REQ, ACQ_RSP, RETRY, WRITE, TRIGGER, WAIT_EVT and DONE.
REQ-005 IDLE: job_ready_o SHALL be 1; on job_valid_i, all job_regs_i words SHALL be latched into an internal copy and the FSM SHALL go to ACQ_REQ.
REQ-006 ACQ_REQ: the block SHALL drive req=1, wen=1, add=0x04, be=4'hF and SHALL go to ACQ_RSP on the cycle req&gnt.
REQ-007 ACQ_RSP: on r_valid with r_id==MASTER_ID, r_data==32'hFFFF_FFFF SHALL go to RETRY; any other value SHALL load job_id_o=r_data[7:0] and go to WRITE with word index k=0.
REQ-008 Responses with a mismatching r_id SHALL be ignored.
REQ-009 RETRY: a counter SHALL count RETRY_CYCLES cycles and then return to ACQ_REQ; RETRY_CYCLES=0 SHALL return on the next cycle.
REQ-010 WRITE: the block SHALL drive req=1, wen=0, be=4'hF, add=JOB_BASE+4k, data=word k.
REQ-011 WRITE: on each gnt, k SHALL increment; the gnt at k==N_JOB_REGS-1 SHALL go to TRIGGER; the k counter SHALL be $clog2(N_JOB_REGS+1) bits wide.
REQ-012 Request hold: while req=1 and gnt=0, add, wen, be, data and id SHALL hold stable; req SHALL never drop before gnt.
REQ-013 Back-to-back: consecutive granted writes SHALL issue with no bubble, one per cycle when gnt stays high.
REQ-014 TRIGGER: the block SHALL issue a write of 0 to 0x00 and go to WAIT_EVT on gnt.
REQ-015 WAIT_EVT: req SHALL be 0; evt_i[0]=1 SHALL go to DONE.
REQ-016 Early event: evt_i[0] asserted before WAIT_EVT SHALL be captured in a sticky flag and consumed on entry to WAIT_EVT.
REQ-017 The sticky early-event flag SHALL be cleared on the job_ready_o&job_valid_i handshake.
REQ-018 DONE: done_o SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-019 Next-job latency: a job_valid_i held high SHALL be accepted in the cycle after DONE.
REQ-020 busy_o SHALL be 1 in every state except IDLE.
REQ-021 Outputs SHALL be registered-free combinational decodes of state, counter and latched data, except job_id_o, which SHALL be a register.
REQ-022 clear_i SHALL have priority over all transitions and return the FSM to IDLE with counters and flags zeroed, abandoning any pending request even if not yet granted.
REQ-023 If clear_i coincides with r_valid, the response SHALL be dropped.

Reset
REQ-024 On rst_ni low, the state SHALL be IDLE, k=0, the retry counter 0, the early-event flag 0, job_id_o=0 and all job words 0.
REQ-025 Reset values SHALL be periph_req_o=0, periph_wen_o=1, busy_o=0, done_o=0 and job_ready_o=1.
REQ-026 Reset SHALL take effect immediately, mid-transaction included.

Structure
REQ-027 The register offsets, the value 32'hFFFF_FFFF and the FSM state enum SHALL live in redmule_pkg.
REQ-028 The block SHALL be a single module with no sub-modules; the periph signals SHALL be flat ports so the bench can bind a hwpe_ctrl_intf_periph master modport externally.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Single job, N_JOB_REGS=4, gnt always 1, ACQUIRE returns 0: required sequence is R 0x04, W 0x40..0x4C, W 0x00; evt_i[0] then gives a done_o pulse; job_id_o=0.
- Random gnt stalls of 0-3 cycles per request: address, data and be stay stable while ungranted; the write order is unchanged.
- ACQUIRE returns 0xFFFFFFFF twice, then 1: two RETRY periods of 4 cycles each, then writes; job_id_o=1.
- evt_i[0] pulsed during TRIGGER before gnt: done_o is asserted one cycle after WAIT_EVT is entered.
- clear_i during WRITE at k=2 with req pending: req drops the next cycle, busy_o=0, and a new job restarts from ACQUIRE.
- rst_ni asserted in WAIT_EVT: all outputs return to their reset values asynchronously.
